// File: rtl/spi_master_multi.sv
// SPI master with configurable word width, chip-select count, SCLK divider and SPI mode.
// A flash wake sequence (MOSI high, CS0 low) runs after reset before the first transfer.
module spi_master_multi #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CS     = 2,
    parameter int unsigned CS_BITS    = 1,
    parameter int unsigned DIV_WIDTH  = 8,
    parameter int unsigned RST_CLOCKS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [CS_BITS-1:0]    cs_sel,
    input  logic                  cs_hold,
    input  logic                  cs_release,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic [NUM_CS-1:0]     spi_cs_n
);

    localparam logic [2:0] StRstSend = 3'd0;
    localparam logic [2:0] StIdle    = 3'd1;
    localparam logic [2:0] StSetup   = 3'd2;
    localparam logic [2:0] StShift   = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;
    localparam logic [2:0] StReset   = (RST_CLOCKS == 0) ? StIdle : StRstSend;

    localparam int unsigned EdgeMax = (2 * DATA_WIDTH > 2 * RST_CLOCKS + 1) ?
                                      2 * DATA_WIDTH : 2 * RST_CLOCKS + 1;
    localparam int unsigned EW = $clog2(EdgeMax + 1);
    localparam logic [EW-1:0] LastEdge = EW'(2 * DATA_WIDTH);
    localparam logic [EW-1:0] PenEdge  = EW'(2 * DATA_WIDTH - 1);
    localparam logic [EW-1:0] RstLast  = EW'(2 * RST_CLOCKS);
    localparam logic [EW-1:0] RstEnd   = EW'(2 * RST_CLOCKS + 1);

    logic [2:0]            state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d, ready_q, ready_d;
    logic                  sclk_q, sclk_d, mosi_q, mosi_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d, sel_n;
    logic                  cpha_q, cpha_d, hold_q, hold_d, rel_q, rel_d;

    logic [DIV_WIDTH-1:0]  div_eff, cnt_inc;
    logic [EW-1:0]         edge_inc;
    logic                  tick, accept;

    // The wake sequence tracks the live divider; transfers use the latched one.
    assign div_eff  = (state_q == StRstSend) ? clk_div : div_q;
    assign tick     = (cnt_q == div_eff);
    assign cnt_inc  = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    assign edge_inc = edge_q + EW'(1);
    assign accept   = tx_valid && ready_q;

    always_comb begin
        for (int i = 0; i < NUM_CS; i++) begin
            sel_n[i] = (CS_BITS'(i) != cs_sel);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        edge_d     = edge_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        cpha_d     = cpha_q;
        hold_d     = hold_q;
        rel_d      = rel_q;

        case (state_q)
            StRstSend: begin
                cs_n_d = ~NUM_CS'(1);
                mosi_d = 1'b1;
                cnt_d  = cnt_inc;
                if (tick) begin
                    if (edge_q == RstEnd) begin
                        state_d = StIdle;
                        cs_n_d  = '1;
                        edge_d  = '0;
                    end else begin
                        edge_d = edge_inc;
                    end
                end
                // One extra half-period of idle SCLK follows the last pulse.
                sclk_d = cpol ^ (edge_d[0] && (edge_d <= RstLast));
            end
            StIdle, StDone: begin
                state_d = StIdle;
                sclk_d  = cpol;
                mosi_d  = 1'b1;
                cnt_d   = '0;
                edge_d  = '0;
                rel_d   = 1'b0;
                if (cs_release) begin
                    cs_n_d = '1;
                end
                if (accept) begin
                    state_d = StSetup;
                    cpha_d  = cpha;
                    hold_d  = cs_hold;
                    div_d   = clk_div;
                    cs_n_d  = sel_n;
                    if (cpha) begin
                        tx_sh_d = tx_data;
                    end else begin
                        mosi_d  = tx_data[DATA_WIDTH-1];
                        tx_sh_d = {tx_data[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            StSetup, StShift: begin
                cnt_d = cnt_inc;
                if (cs_release) begin
                    rel_d = 1'b1;
                end
                if (tick) begin
                    if (edge_q == LastEdge) begin
                        state_d    = StDone;
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        mosi_d     = 1'b1;
                        edge_d     = '0;
                        rel_d      = 1'b0;
                        if (!hold_q || rel_q || cs_release) begin
                            cs_n_d = '1;
                        end
                    end else begin
                        state_d = StShift;
                        edge_d  = edge_inc;
                        sclk_d  = ~sclk_q;
                        // Odd edges lead; cpha selects whether they sample or drive.
                        if (edge_inc[0] ^ cpha_q) begin
                            rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], spi_miso};
                        end else if (cpha_q || (edge_q != PenEdge)) begin
                            mosi_d  = tx_sh_q[DATA_WIDTH-1];
                            tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = StReset;
        endcase

        ready_d = (state_d == StIdle) || (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StReset;
            cnt_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ready_q    <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
            cs_n_q     <= '1;
            cpha_q     <= 1'b0;
            hold_q     <= 1'b0;
            rel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ready_q    <= ready_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            cpha_q     <= cpha_d;
            hold_q     <= hold_d;
            rel_q      <= rel_d;
        end
    end

    assign tx_ready = ready_q;
    assign busy     = !ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi: expected words are queued at acceptance and
// compared when rx_valid fires; timing and pin behaviour are checked along the way.
module tb_spi_master_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpol, cpha, cs_hold, cs_release, tx_valid;
    logic [7:0] clk_div, tx_data;
    logic [0:0] cs_sel;
    logic       tx_ready, rx_valid, busy, spi_sclk, spi_mosi, spi_miso;
    logic [7:0] rx_data;
    logic [1:0] spi_cs_n;

    spi_master_multi dut (
        .clk        (clk),
        .reset      (reset),
        .cpol       (cpol),
        .cpha       (cpha),
        .clk_div    (clk_div),
        .cs_sel     (cs_sel),
        .cs_hold    (cs_hold),
        .cs_release (cs_release),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_cs_n   (spi_cs_n)
    );

    always #5 clk = ~clk;

    // Slave model: shifts slave_word out MSB first on each leading (falling) edge.
    logic       loopback = 1'b1;
    logic [7:0] slave_word = 8'h00;
    logic [7:0] mon_sh = 8'h00;
    int         lead_cnt = 0;
    int         lead_base = 0;
    int         lead_rel;

    always @(negedge spi_sclk) lead_cnt <= lead_cnt + 1;
    always @(posedge spi_sclk) if (spi_cs_n !== 2'b11) mon_sh <= {mon_sh[6:0], spi_mosi};

    assign lead_rel = lead_cnt - lead_base;
    assign spi_miso = loopback ? spi_mosi :
                      ((lead_rel >= 1 && lead_rel <= 8) ? slave_word[3'(8 - lead_rel)] : 1'b0);

    int         n_vec = 0, n_err = 0, cyc = 0, rx_cnt = 0, t_rx = 0, t_acc = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (reset) begin
            exp_q.delete();
        end else if (rx_valid === 1'b1) begin
            rx_cnt++;
            t_rx = cyc;
            check("rx_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (tx_ready !== 1'b1 && k < 500) begin
            tick();
            k++;
        end
        check("ready_wait", 32'(tx_ready), 32'd1);
    endtask

    task automatic wait_rx(input int n0);
        int k = 0;
        while (rx_cnt == n0 && k < 500) begin
            tick();
            k++;
        end
        check("rx_seen", 32'(rx_cnt), 32'(n0 + 1));
    endtask

    // Returns at the negedge of cycle T+1; inputs are scrambled to prove they were latched.
    task automatic send(input logic [7:0] d, input logic [7:0] e, input logic sel,
                        input logic hold, input logic pol, input logic pha,
                        input logic [7:0] div);
        wait_ready();
        tx_data  = d;
        cs_sel   = sel;
        cs_hold  = hold;
        cpol     = pol;
        cpha     = pha;
        clk_div  = div;
        tx_valid = 1'b1;
        exp_q.push_back(e);
        t_acc = cyc;
        tick();
        tx_valid = 1'b0;
        tx_data  = ~d;
        cs_sel   = ~sel;
        cs_hold  = ~hold;
        cpha     = ~pha;
        clk_div  = 8'hff;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs_n"}, 32'(spi_cs_n), 32'h3);
        check({tag, "_sclk"}, 32'(spi_sclk), 32'h0);
        check({tag, "_mosi"}, 32'(spi_mosi), 32'h1);
        check({tag, "_ready"}, 32'(tx_ready), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h1);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    endtask

    task automatic do_wake();
        int   k = 0, pulses = 0, bad = 0, t0;
        logic prev;
        cpol    = 1'b0;
        clk_div = 8'h00;
        prev    = spi_sclk;
        t0      = cyc;
        reset   = 1'b0;
        while (tx_ready !== 1'b1 && k < 300) begin
            tick();
            k++;
            if (spi_sclk && !prev) pulses++;
            prev = spi_sclk;
            if (tx_ready !== 1'b1 && (spi_cs_n[0] !== 1'b0 || spi_mosi !== 1'b1)) bad++;
        end
        check("wake_pulses", 32'(pulses), 32'd16);
        check("wake_cs0_mosi", 32'(bad), 32'd0);
        check("wake_time_ok", 32'((cyc - t0) >= 33 && (cyc - t0) <= 35), 32'd1);
        check("wake_cs_n_end", 32'(spi_cs_n), 32'h3);
        check("wake_ready", 32'(tx_ready), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int   n0, k, tog, last, hmin, hmax;
        logic prev;
        reset = 1'b1; cpol = 1'b0; cpha = 1'b0; clk_div = 8'h00; cs_sel = 1'b0;
        cs_hold = 1'b0; cs_release = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        ticks(2);
        check_reset_vals("rst");
        do_wake();

        // Mode 0 loopback, H=1
        n0 = rx_cnt;
        send(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        ticks(8);
        check("m0_busy", 32'(busy), 32'h1);
        check("m0_cs_sel", 32'(spi_cs_n), 32'h2);
        wait_rx(n0);
        check("m0_latency", 32'(t_rx - t_acc), 32'd18);
        check("m0_cs_release", 32'(spi_cs_n), 32'h3);
        check("m0_ready_done", 32'(tx_ready), 32'h1);

        // Mode 1 loopback, H=2
        n0 = rx_cnt;
        send(8'h96, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        wait_rx(n0);
        check("m1_latency", 32'(t_rx - t_acc), 32'd35);

        // Mode 2 loopback, H=1
        n0 = rx_cnt;
        send(8'h0F, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        wait_rx(n0);

        // Mode 3 against the slave model, H=4
        loopback = 1'b0;
        slave_word = 8'h3C;
        cpol = 1'b1;
        ticks(2);
        check("m3_idle_high", 32'(spi_sclk), 32'h1);
        lead_base = lead_cnt;
        n0 = rx_cnt;
        send(8'hC3, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
        prev = spi_sclk; tog = 0; last = 0; hmin = 999; hmax = 0; k = 0;
        while (rx_cnt == n0 && k < 500) begin
            tick();
            k++;
            if (spi_sclk !== prev) begin
                if (tog > 0) begin
                    if (cyc - last < hmin) hmin = cyc - last;
                    if (cyc - last > hmax) hmax = cyc - last;
                end
                last = cyc;
                tog++;
            end
            prev = spi_sclk;
        end
        check("m3_rx_seen", 32'(rx_cnt), 32'(n0 + 1));
        check("m3_edges", 32'(tog), 32'd16);
        check("m3_half_min", 32'(hmin), 32'd4);
        check("m3_half_max", 32'(hmax), 32'd4);
        check("m3_mosi_word", 32'(mon_sh), 32'hC3);
        check("m3_latency", 32'(t_rx - t_acc), 32'd69);
        check("m3_sclk_end", 32'(spi_sclk), 32'h1);

        // CS hold across transfers, switch to another CS, then release in IDLE
        loopback = 1'b1;
        n0 = rx_cnt;
        send(8'h11, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        wait_rx(n0);
        check("hold_done", 32'(spi_cs_n), 32'h1);
        ticks(3);
        check("hold_gap", 32'(spi_cs_n), 32'h1);
        n0 = rx_cnt;
        send(8'h22, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        check("hold_second", 32'(spi_cs_n), 32'h1);
        wait_rx(n0);
        check("hold_done2", 32'(spi_cs_n), 32'h1);
        n0 = rx_cnt;
        send(8'h33, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        check("cs_switch", 32'(spi_cs_n), 32'h2);
        wait_rx(n0);
        check("hold_cs0", 32'(spi_cs_n), 32'h2);
        ticks(2);
        cs_release = 1'b1;
        tick();
        cs_release = 1'b0;
        check("cs_release_idle", 32'(spi_cs_n), 32'h3);

        // tx_valid pulsed during SHIFT is dropped
        n0 = rx_cnt;
        send(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        ticks(10);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        wait_rx(n0);
        ticks(60);
        check("single_rx", 32'(rx_cnt), 32'(n0 + 1));

        // Reset just after edge 7 aborts the transfer and reruns the wake sequence
        n0 = rx_cnt;
        send(8'h77, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        while (cyc < t_acc + 8) tick();
        reset = 1'b1;
        #1;
        check_reset_vals("abort");
        ticks(2);
        do_wake();
        ticks(20);
        check("abort_no_rx", 32'(rx_cnt), 32'(n0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
# spi_master_multi

Parametrised SPI master: the next generation of the byte-wide flash SPI core. Adds configurable word width, chip-select count, a runtime SCLK divider, all four SPI modes, chip-select hold across transfers and a valid/ready handshake. Keeps the power-on flash wake sequence (MOSI high for a fixed clock count). Sits between the CPU bus peripheral decoder and the board SPI pins (flash, SD card).

## Interface
- DATA_WIDTH, 8: bits per transfer, MSB first, ≥2.
- NUM_CS, 2: number of chip-select outputs, ≥1.
- CS_BITS, 1: width of cs_sel; must satisfy 2^CS_BITS ≥ NUM_CS.
- DIV_WIDTH, 8: width of clk_div.
- RST_CLOCKS, 16: SCLK pulses in the post-reset wake sequence; 0 disables the sequence.

- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- clk_div  in  DIV_WIDTH  SCLK half-period is clk_div+1 clk cycles.
- cs_sel  in  CS_BITS  chip select for the transfer.
- cs_hold  in  1  keep CS asserted after this transfer.
- cs_release  in  1  one-cycle pulse that deasserts every CS.
- tx_data  in  DATA_WIDTH  word to send.
- tx_valid  in  1  request a transfer.
- tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high.
- rx_data  out  DATA_WIDTH  last received word; holds until the next transfer completes.
- rx_valid  out  1  one-cycle completion pulse.
- busy  out  1  equals !tx_ready.
- spi_sclk  out  1  SPI clock, registered.
- spi_mosi  out  1  SPI data out, registered.
- spi_miso  in  1  SPI data in.
- spi_cs_n  out  NUM_CS  active-low chip selects, registered.

## Operation
- States: RSTSEND, IDLE, SETUP, SHIFT, DONE.
- Reset values while reset is high: spi_cs_n all ones, spi_sclk 0, spi_mosi 1, tx_ready 0, busy 1, rx_valid 0, rx_data 0.
  - State after reset is RSTSEND, or IDLE if RST_CLOCKS=0.
  - Reset mid-transfer aborts immediately; no rx_valid is produced; the wake sequence reruns.
- RSTSEND
  - spi_cs_n[0]=0, spi_mosi=1.
  - Emits RST_CLOCKS SCLK pulses using the live clk_div and cpol.
  - Then spi_cs_n goes all ones and the state moves to IDLE.
- IDLE
  - tx_ready=1; spi_sclk follows cpol with a one-cycle register delay.
  - cs_release pulse sets all spi_cs_n to 1 on the next cycle.
  - A tx_valid that arrives while tx_ready is low is ignored; it is not queued.
- Acceptance (cycle T)
  - Latches tx_data, cs_sel, cs_hold, cpol, cpha and clk_div; later input changes do not affect the transfer.
  - Next state is SETUP.
- SETUP
  - At T+1, the selected spi_cs_n goes low and all other spi_cs_n go high.
  - If cpha=0, spi_mosi is set to the MSB.
  - Lasts one half-period.
- SHIFT
  - 2×DATA_WIDTH SCLK edges.
  - Sampling edge: shift in spi_miso, using the value present at the clk edge that toggles spi_sclk.
  - Drive edge: put the next bit on spi_mosi.
    - cpha=0: driving happens on trailing edges; no drive after the last edge.
    - cpha=1: driving happens on leading edges, MSB first.
- DONE
  - Reached one half-period after the last edge.
  - rx_data is updated, rx_valid=1 for one cycle, tx_ready=1 in the same cycle, state returns to IDLE.
  - spi_cs_n goes all ones in the same cycle unless the latched cs_hold=1.
  - spi_mosi returns to 1.
- cs_release during SETUP, SHIFT or DONE is registered and applied at DONE, overriding cs_hold.
- A held CS followed by a transfer to a different cs_sel switches to the new CS at T+1. Only one CS is ever low.

## Timing
- Half-period H = clk_div+1 cycles. Edge k (k=1..2W, W=DATA_WIDTH) occurs at T+1+k·H.
- rx_valid occurs at T+1+(2W+1)·H. With W=8 and clk_div=0, that is T+18.
- Back-to-back transfers: tx_valid held high is accepted on the rx_valid cycle. Throughput is one word per (2W+1)·H+1 cycles.
- Wake sequence: RST_CLOCKS pulses of period 2H. tx_ready rises (2·RST_CLOCKS+2)·H cycles after reset deasserts, ±1 cycle.
- Divider arithmetic is unsigned DIV_WIDTH bits. clk_div=all-ones gives H=2^DIV_WIDTH with no overflow.

## Test plan
- After reset with RST_CLOCKS=16 and clk_div=0 -> exactly 16 SCLK pulses with spi_cs_n[0]=0 and spi_mosi=1 throughout; then spi_cs_n=2'b11 and tx_ready=1.
- Mode 0, clk_div=0, spi_miso looped to spi_mosi, send 0xA5 accepted at T -> rx_valid at T+18 with rx_data=0xA5; spi_cs_n back to all ones at T+18.
- Mode 3 (cpol=1, cpha=1), clk_div=3, slave model returning 0x3C, send 0xC3 -> MOSI decodes 0xC3, rx_data=0x3C; SCLK idles high with 4-cycle half-periods.
- Two transfers on cs_sel=1 with cs_hold=1 on the first -> spi_cs_n[1] stays low between them; cs_release in IDLE -> all ones the next cycle.
- tx_valid pulsed during SHIFT -> ignored, and exactly one rx_valid is produced.
- Reset asserted at edge 7 of a transfer -> outputs take their reset values immediately, no rx_valid is produced, and the wake sequence reruns.
